// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO and issue/capture sequencer for a combinational 4-bit ALU
// Optional accumulator chaining is enabled with `define ALU_SEQ_ACCUM_EN.
module alu_cmd_sequencer #(
    parameter int CMD_DEPTH = 4,
    parameter int DW        = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [2:0]                   cmd_op,
    input  logic [DW-1:0]                cmd_a,
    input  logic [DW-1:0]                cmd_b,
    input  logic                         cmd_use_acc,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DW-1:0]                rsp_result,
    output logic [2:0]                   rsp_flags,
    output logic [DW-1:0]                alu_a,
    output logic [DW-1:0]                alu_b,
    output logic [2:0]                   alu_ctrl,
    input  logic [DW-1:0]                alu_result,
    input  logic                         alu_carry,
    input  logic                         alu_overflow,
    input  logic                         alu_zero,
    output logic [$clog2(CMD_DEPTH):0]   cmd_count,
    output logic                         busy
);

    localparam int AW = $clog2(CMD_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    state_t state, state_next;

    logic [2:0]    mem_op [CMD_DEPTH];
    logic [DW-1:0] mem_a  [CMD_DEPTH];
    logic [DW-1:0] mem_b  [CMD_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic capture;
    logic rsp_clear;
    logic [DW-1:0] head_a;

    assign full      = (cmd_count == CW'(CMD_DEPTH));
    assign empty     = (cmd_count == '0);
    assign cmd_ready = !full;
    // A pop in the same cycle never opens room for a push while full.
    assign push      = cmd_valid && !full;
    assign busy      = (state != IDLE) || !empty;

`ifdef ALU_SEQ_ACCUM_EN
    logic          mem_acc [CMD_DEPTH];
    logic [DW-1:0] acc;

    // Per-entry accumulator select, written alongside the operands.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_acc[wr_ptr] <= cmd_use_acc;
        end
    end

    // Accumulator tracks every captured result so a chained command sees it on issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (capture) begin
            acc <= alu_result;
        end
    end

    assign head_a = mem_acc[rd_ptr] ? acc : mem_a[rd_ptr];
`else
    logic unused_use_acc;
    assign unused_use_acc = cmd_use_acc;
    assign head_a         = mem_a[rd_ptr];
`endif

    // Command storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_op[wr_ptr] <= cmd_op;
            mem_a[wr_ptr]  <= cmd_a;
            mem_b[wr_ptr]  <= cmd_b;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cmd_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cmd_count <= cmd_count + CW'(push) - CW'(pop);
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the load/capture/release strobes that drive the datapath.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        capture    = 1'b0;
        rsp_clear  = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                capture    = 1'b1;
                state_next = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (rsp_ready) begin
                    rsp_clear = 1'b1;
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ALU operand registers hold the last issued command; response registers hold until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= 3'b000;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= 3'b000;
        end else begin
            if (pop) begin
                alu_a    <= head_a;
                alu_b    <= mem_b[rd_ptr];
                alu_ctrl <= mem_op[rd_ptr];
            end
            if (capture) begin
                rsp_valid  <= 1'b1;
                rsp_result <= alu_result;
                rsp_flags  <= {alu_carry, alu_overflow, alu_zero};
            end else if (rsp_clear) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed scoreboard bench for alu_cmd_sequencer
module tb_alu_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int DW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = '0;
    logic [DW-1:0] cmd_a = '0;
    logic [DW-1:0] cmd_b = '0;
    logic          cmd_use_acc = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_result;
    logic [2:0]    rsp_flags;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [2:0]    alu_ctrl;
    logic [DW-1:0] alu_result;
    logic          alu_carry;
    logic          alu_overflow;
    logic          alu_zero;
    logic [2:0]    cmd_count;
    logic          busy;

    logic [6:0] sb[$];
    int checks = 0;
    int errors = 0;
    int rsp_seen = 0;
    int cyc = 0;
    int last_t = -1;
    int gap_err = 0;
    bit drain = 1'b0;

    alu_cmd_sequencer #(.CMD_DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .cmd_count(cmd_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference 4-bit ALU: returns {result, carry, overflow, zero}.
    function automatic logic [6:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        logic [3:0] r;
        logic c;
        logic ov;
        s = '0;
        r = '0;
        c = 1'b0;
        ov = 1'b0;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; ov = (a[3] == b[3]) && (r[3] != a[3]); end
            3'd1: begin s = {1'b0, a} + {1'b0, ~b} + 5'd1; r = s[3:0]; c = s[4]; ov = (a[3] != b[3]) && (r[3] != a[3]); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: r = a;
            default: r = b;
        endcase
        return {r, c, ov, (r == 4'd0)};
    endfunction

    always_comb {alu_result, alu_carry, alu_overflow, alu_zero} = alu_f(alu_ctrl, alu_a, alu_b);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: each handshake pops the scoreboard in command order.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            logic [6:0] exp;
            rsp_seen++;
            if (drain) begin
                if (last_t >= 0 && (cyc - last_t) != 2) gap_err++;
                last_t = cyc;
            end
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_rsp observed=%0h expected=none", rsp_result);
            end
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                check("rsp_result", rsp_result, exp[6:3]);
                check("rsp_flags", rsp_flags, exp[2:0]);
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic ua, input logic [6:0] exp, input bit track);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("send_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        cmd_use_acc = ua;
        if (track) sb.push_back(exp);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_use_acc = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (!busy && !rsp_valid) break;
            @(posedge clk); #1;
        end
        check("wait_idle_busy", busy, 0);
    endtask

    initial begin
        int k;
        int seen0;
        logic ok;
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_alu_ctrl", alu_ctrl, 0);
        check("rst_cmd_count", cmd_count, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_flags", rsp_flags, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD 7+1 with latency checks
        send(3'd0, 4'd7, 4'd1, 1'b0, {4'h8, 3'b010}, 1'b1);
        check("add_count_after_push", cmd_count, 1);
        check("add_rsp_valid_n0", rsp_valid, 0);
        @(posedge clk); #1;
        check("add_alu_a", alu_a, 7);
        check("add_alu_b", alu_b, 1);
        check("add_alu_ctrl", alu_ctrl, 0);
        check("add_rsp_valid_n1", rsp_valid, 0);
        @(posedge clk); #1;
        check("add_rsp_valid_n2", rsp_valid, 1);
        check("add_result", rsp_result, 4'h8);
        check("add_flags", rsp_flags, 3'b010);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("add_rsp_cleared", rsp_valid, 0);
        check("add_busy_idle", busy, 0);

        // SUB 3-3 held under backpressure
        send(3'd1, 4'd3, 4'd3, 1'b0, {4'h0, 3'b101}, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("sub_hold_valid", rsp_valid, 1);
            check("sub_hold_result", rsp_result, 4'h0);
            check("sub_hold_flags", rsp_flags, 3'b101);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_hold_alu_a", alu_a, 3);
        check("idle_hold_alu_b", alu_b, 3);
        check("idle_hold_alu_ctrl", alu_ctrl, 1);

        // Fill under backpressure: CMD_DEPTH+1 accepted
        k = 0;
        for (int i = 0; i < 8; i++) begin
            op = 3'(k);
            a = 4'(k * 3 + 1);
            b = 4'(k + 5);
            cmd_valid = 1'b1;
            cmd_op = op;
            cmd_a = a;
            cmd_b = b;
            ok = cmd_ready;
            @(posedge clk); #1;
            if (ok) begin
                sb.push_back(alu_f(op, a, b));
                k++;
            end
        end
        check("fill_accepted", k, DEPTH + 1);
        check("fill_cmd_ready", cmd_ready, 0);
        check("fill_cmd_count", cmd_count, DEPTH);

        // Pop while full with cmd_valid high: push refused, then drain in order
        seen0 = rsp_seen;
        drain = 1'b1;
        last_t = -1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("full_no_bypass_count", cmd_count, DEPTH - 1);
        wait_idle(40);
        drain = 1'b0;
        check("drain_rsp_count", rsp_seen - seen0, DEPTH + 1);
        check("drain_gap_err", gap_err, 0);
        check("drain_sb_empty", sb.size(), 0);
        check("drain_cmd_count", cmd_count, 0);

        // Reset in WAIT_RSP with three queued
        rsp_ready = 1'b0;
        send(3'd0, 4'd1, 4'd1, 1'b0, '0, 1'b0);
        send(3'd0, 4'd2, 4'd1, 1'b0, '0, 1'b0);
        send(3'd0, 4'd3, 4'd1, 1'b0, '0, 1'b0);
        send(3'd0, 4'd4, 4'd1, 1'b0, '0, 1'b0);
        check("pre_rst_count", cmd_count, 3);
        check("pre_rst_rsp_valid", rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_count", cmd_count, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        seen0 = rsp_seen;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_no_rsp", rsp_seen - seen0, 0);
        check("post_rst_rsp_valid", rsp_valid, 0);
        check("post_rst_busy", busy, 0);

        // Accumulator chaining
        seen0 = rsp_seen;
        send(3'd0, 4'd5, 4'd2, 1'b0, {4'h7, 3'b000}, 1'b1);
`ifdef ALU_SEQ_ACCUM_EN
        send(3'd0, 4'd0, 4'd1, 1'b1, {4'h8, 3'b010}, 1'b1);
`else
        send(3'd0, 4'd0, 4'd1, 1'b1, {4'h1, 3'b000}, 1'b1);
`endif
        wait_idle(40);
        check("acc_rsp_count", rsp_seen - seen0, 2);
        check("acc_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
